// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
//   arb_state_t     : sequencer state encoding
//   DEV_W/REG_W/DAT_W : command field widths
//   TIMEOUT_CYC_DEF : default watchdog limit (used with I2C_ARB_TIMEOUT_EN)
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int DEV_W           = 7;
    localparam int REG_W           = 8;
    localparam int DAT_W           = 8;
    localparam int TMO_CNT_W       = 16;
    localparam int TIMEOUT_CYC_DEF = 65535;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request vector
//   ptr     : index where the search starts (highest priority this round)
//   win     : one-hot winner (all zero when no request)
//   win_idx : index of the winner (0 when no request)
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx
);

    logic found;
    int   idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master command port between NUM_REQ requesters using a
// round-robin grant held for the whole transaction.
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog
// that ends a stuck transaction with err=1 after TIMEOUT_CYC cycles.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req/req_wr/req_dev/req_reg/req_wdata : per-requester command (flattened)
//   gnt, done                      : one-hot grant and completion pulse
//   rdata, err                     : read byte and NACK/timeout status
//   m_start, m_wr, m_dev, m_reg, m_wdata : command to the I2C master
//   m_busy, m_done, m_rdata, m_nack      : status from the I2C master
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrate; capture winner fields onto m_* and raise gnt
// ST_ISSUE | wait for master idle, then strobe m_start
// ST_WAIT  | wait for m_done (or watchdog expiry)
// ST_RESP  | done pulse visible, gnt dropped; return to IDLE
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_wr,
    input  logic [NUM_REQ*DEV_W-1:0] req_dev,
    input  logic [NUM_REQ*REG_W-1:0] req_reg,
    input  logic [NUM_REQ*DAT_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [DAT_W-1:0]         rdata,
    output logic                     err,
    output logic                     m_start,
    output logic                     m_wr,
    output logic [DEV_W-1:0]         m_dev,
    output logic [REG_W-1:0]         m_reg,
    output logic [DAT_W-1:0]         m_wdata,
    input  logic                     m_busy,
    input  logic                     m_done,
    input  logic [DAT_W-1:0]         m_rdata,
    input  logic                     m_nack
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("i2c_master_arbiter: parameter out of range");
    end

    arb_state_t           state_q,   state_d;
    logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
    logic [NUM_REQ-1:0]   done_q,    done_d;
    logic [DAT_W-1:0]     rdata_q,   rdata_d;
    logic                 err_q,     err_d;
    logic                 m_start_q, m_start_d;
    logic                 m_wr_q,    m_wr_d;
    logic [DEV_W-1:0]     m_dev_q,   m_dev_d;
    logic [REG_W-1:0]     m_reg_q,   m_reg_d;
    logic [DAT_W-1:0]     m_wdata_q, m_wdata_d;
    logic [PTR_W-1:0]     ptr_q,     ptr_d;
    logic [PTR_W-1:0]     win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0]   win;
    logic [PTR_W-1:0]     win_idx;
    logic                 txn_end;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    i2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        m_start_d = 1'b0;
        m_wr_d    = m_wr_q;
        m_dev_d   = m_dev_q;
        m_reg_d   = m_reg_q;
        m_wdata_d = m_wdata_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        txn_end   = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d     = win;
                    win_idx_d = win_idx;
                    m_wr_d    = req_wr[win_idx];
                    m_dev_d   = req_dev[int'(win_idx)*DEV_W +: DEV_W];
                    m_reg_d   = req_reg[int'(win_idx)*REG_W +: REG_W];
                    m_wdata_d = req_wdata[int'(win_idx)*DAT_W +: DAT_W];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!m_busy) begin
                    m_start_d = 1'b1;
                    state_d   = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    // a write leaves the last read byte in place
                    if (!m_wr_q) begin
                        rdata_d = m_rdata;
                    end
                    err_d   = m_nack;
                    txn_end = 1'b1;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    txn_end = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
                // done/gnt are registered, so they change as RESP is entered
                if (txn_end) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = (win_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            m_start_q <= 1'b0;
            m_wr_q    <= 1'b0;
            m_dev_q   <= '0;
            m_reg_q   <= '0;
            m_wdata_q <= '0;
            ptr_q     <= '0;
            win_idx_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            m_start_q <= m_start_d;
            m_wr_q    <= m_wr_d;
            m_dev_q   <= m_dev_d;
            m_reg_q   <= m_reg_d;
            m_wdata_q <= m_wdata_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign m_start = m_start_q;
    assign m_wr    = m_wr_q;
    assign m_dev   = m_dev_q;
    assign m_reg   = m_reg_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter with a small I2C master model.
// Master model: replies 3 cycles after m_start; read data = reg ^ 8'hBF,
// write returns 8'hEE on m_rdata, device 0x3C NACKs.
module tb_i2c_master_arbiter;
    import i2c_arb_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_wr;
    logic [N*7-1:0] req_dev;
    logic [N*8-1:0] req_reg, req_wdata;
    logic [N-1:0]   gnt, done;
    logic [7:0]     rdata;
    logic           err, m_start, m_wr;
    logic [6:0]     m_dev;
    logic [7:0]     m_reg, m_wdata;
    logic           m_busy, m_done, m_nack;
    logic [7:0]     m_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    logic model_en = 1'b1;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .m_start(m_start), .m_wr(m_wr), .m_dev(m_dev),
        .m_reg(m_reg), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
        .m_rdata(m_rdata), .m_nack(m_nack)
    );

    // master model, driven on the falling edge
    initial begin : master_model
        logic       pend;
        int         lat;
        logic       cap_wr;
        logic [6:0] cap_dev;
        logic [7:0] cap_reg;
        pend = 1'b0; lat = 0; cap_wr = 1'b0; cap_dev = '0; cap_reg = '0;
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            m_nack = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (m_start && model_en) begin
                pend = 1'b1; lat = 3;
                cap_wr = m_wr; cap_dev = m_dev; cap_reg = m_reg;
            end else if (pend && model_en) begin
                lat--;
                if (lat == 0) begin
                    pend    = 1'b0;
                    m_done  = 1'b1;
                    m_rdata = cap_wr ? 8'hEE : (cap_reg ^ 8'hBF);
                    m_nack  = (cap_dev == 7'h3C);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (m_start) start_cnt++;
            if (|done)   done_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: sim time exceeded, required bench completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt();
        int c = 0;
        while (gnt == '0 && c < 200) begin tick(); c++; end
    endtask

    task automatic wait_done();
        int c = 0;
        while (done == '0 && c < 200) begin tick(); c++; end
    endtask

    task automatic set_fields(input int idx, input logic wr, input logic [6:0] dev,
                              input logic [7:0] rg, input logic [7:0] wd);
        req_wr[idx]          = wr;
        req_dev[idx*7 +: 7]  = dev;
        req_reg[idx*8 +: 8]  = rg;
        req_wdata[idx*8 +: 8] = wd;
    endtask

    typedef struct {
        int         idx;
        logic       wr;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [3:0] exp_gnt;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int s0;
        tick();
        set_fields(v.idx, v.wr, v.dev, v.rg, v.wd);
        req[v.idx] = 1'b1;
        tick();
        chk("vec_gnt", gnt, v.exp_gnt);
        chk("vec_m_wr", m_wr, v.wr);
        chk("vec_m_dev", m_dev, v.dev);
        chk("vec_m_reg", m_reg, v.rg);
        chk("vec_m_wdata", m_wdata, v.wd);
        s0 = start_cnt;
        tick();
        chk("vec_m_start", m_start, 1'b1);
        wait_done();
        chk("vec_done", done, v.exp_gnt);
        chk("vec_done_align", m_done, 1'b1);
        chk("vec_gnt_clr", gnt, 4'b0000);
        chk("vec_rdata", rdata, v.exp_rdata);
        chk("vec_err", err, v.exp_err);
        chk("vec_starts", start_cnt - s0, 1);
        req[v.idx] = 1'b0;
    endtask

    initial begin : main
        int order[5];
        int s0, bad, d0, c;
        order = '{0, 1, 2, 3, 0};
        vecs[0] = '{1, 1'b0, 7'h50, 8'h1A, 8'h00, 4'b0010, 8'hA5, 1'b0};
        vecs[1] = '{2, 1'b1, 7'h3C, 8'h05, 8'h77, 4'b0100, 8'hA5, 1'b1};
        vecs[2] = '{0, 1'b0, 7'h50, 8'h00, 8'h00, 4'b0001, 8'hBF, 1'b0};
        vecs[3] = '{3, 1'b1, 7'h50, 8'h10, 8'h33, 4'b1000, 8'hBF, 1'b0};
        vecs[4] = '{3, 1'b0, 7'h51, 8'hFF, 8'h00, 4'b1000, 8'h40, 1'b0};
        vecs[5] = '{0, 1'b0, 7'h3C, 8'h44, 8'h00, 4'b0001, 8'hFB, 1'b1};

        rst = 1'b1; req = '0; req_wr = '0; req_dev = '0; req_reg = '0;
        req_wdata = '0; m_busy = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_fields", {m_wr, m_dev, m_reg, m_wdata}, 0);
        chk("rst_rdata_err", {rdata, err}, 0);
        rst = 1'b0;

        // rotation: all four request at once; 0 re-requests after its turn
        for (int k = 0; k < N; k++) set_fields(k, 1'b0, 7'h50, 8'(8'h10 + k), 8'h00);
        tick();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_gnt();
            chk("rr_gnt", gnt, 1 << order[t]);
            wait_done();
            chk("rr_done", done, 1 << order[t]);
            chk("rr_rdata", rdata, (8'h10 + order[t]) ^ 8'hBF);
            req[order[t]] = 1'b0;
            if (t == 0) begin
                tick();
                req[0] = 1'b1;
            end
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // master busy for 20 cycles after the grant
        tick();
        m_busy = 1'b1;
        set_fields(2, 1'b0, 7'h50, 8'h22, 8'h00);
        req[2] = 1'b1;
        tick();
        chk("busy_gnt", gnt, 4'b0100);
        s0 = start_cnt; bad = 0;
        repeat (20) begin
            tick();
            if (m_start !== 1'b0 || gnt !== 4'b0100) bad++;
        end
        chk("busy_hold", bad, 0);
        m_busy = 1'b0;
        tick();
        chk("busy_start", m_start, 1'b1);
        wait_done();
        chk("busy_done", done, 4'b0100);
        chk("busy_starts", start_cnt - s0, 1);
        chk("busy_rdata", rdata, 8'h9D);
        req[2] = 1'b0;

        // reset while waiting for the master
        tick();
        model_en = 1'b0;
        set_fields(1, 1'b0, 7'h50, 8'h61, 8'h00);
        req[1] = 1'b1;
        wait_gnt();
        tick();
        chk("rw_start", m_start, 1'b1);
        repeat (3) tick();
        d0 = done_cnt;
        rst = 1'b1; req[1] = 1'b0;
        tick();
        rst = 1'b0;
        chk("rw_gnt", gnt, 0);
        chk("rw_done", done, 0);
        chk("rw_m", {m_start, m_wr, m_dev, m_reg, m_wdata}, 0);
        chk("rw_rdata_err", {rdata, err}, 0);
        repeat (5) tick();
        chk("rw_no_done", done_cnt - d0, 0);
        model_en = 1'b1;
        set_fields(3, 1'b0, 7'h50, 8'h02, 8'h00);
        req = 4'b1010;
        wait_gnt();
        chk("rw_ptr_gnt", gnt, 4'b0010);
        wait_done();
        chk("rw_rdata1", rdata, 8'hDE);
        req[1] = 1'b0;
        wait_gnt();
        chk("rw_gnt3", gnt, 4'b1000);
        wait_done();
        chk("rw_rdata3", rdata, 8'hBD);
        req[3] = 1'b0;

`ifdef I2C_ARB_TIMEOUT_EN
        tick();
        model_en = 1'b0;
        set_fields(0, 1'b0, 7'h50, 8'h07, 8'h00);
        req[0] = 1'b1;
        wait_gnt();
        tick();
        chk("tmo_start", m_start, 1'b1);
        c = 0;
        while (done == '0 && c < 300) begin tick(); c++; end
        chk("tmo_latency", c, 101);
        chk("tmo_done", done, 4'b0001);
        chk("tmo_err", err, 1'b1);
        chk("tmo_rdata", rdata, 8'hBD);
        req[0] = 1'b0;
        model_en = 1'b1;
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
